// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - load data path: word-aligned reads, merge/shift, sign/zero extension
// Optional feature macro: LOAD_MISALIGN_SPLIT_EN (two-read handling of word-crossing loads).
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_misalign
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int END_W = OFF_W + 2;
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(NB);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  state_t           state;
  logic [1:0]       lg_q;     // log2 of access size in bytes
  logic             uns_q;    // zero-extend result
  logic [OFF_W-1:0] off_q;    // byte offset inside the first word

`ifdef LOAD_MISALIGN_SPLIT_EN
  logic              cross_q;
  logic [DATA_W-1:0] w0_q;
`endif

  logic             rd0_last;
  logic [1:0]       req_lg;
  logic             req_uns;
  logic [OFF_W-1:0] req_off;
  logic [END_W-1:0] req_end;
  logic             req_cross;

  // Decode size/extension of the incoming request and whether it spans two words
  always_comb begin
    req_lg  = req_funct3[1:0];
    req_uns = req_funct3[2];
    // A 32-bit datapath has no doubleword or word-unsigned loads; both fold onto LW
    if (DATA_W == 32 && req_funct3[1]) begin
      req_lg  = 2'd2;
      req_uns = 1'b0;
    end
    req_off   = req_addr[OFF_W-1:0];
    req_end   = END_W'(req_off) + (END_W'(1) << req_lg);
    req_cross = req_end > END_W'(NB);
  end

  // Decide whether the first read completes the access
  always_comb begin
`ifdef LOAD_MISALIGN_SPLIT_EN
    rd0_last = !cross_q;
`else
    rd0_last = 1'b1;
`endif
  end

  // Shift the {hi,lo} pair down by the byte offset, then extend from the access size
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] hi,
                                              input logic [DATA_W-1:0] lo,
                                              input logic [OFF_W-1:0]  off,
                                              input logic [1:0]        lg,
                                              input logic              uns);
    logic [2*DATA_W-1:0] sh;
    logic [DATA_W-1:0]   res;
    logic                sgn;
    int                  nbits;
    sh    = {hi, lo} >> {off, 3'b000};
    res   = sh[DATA_W-1:0];
    nbits = 8 << lg;
    sgn   = sh[nbits-1];
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= nbits) res[i] = uns ? 1'b0 : sgn;
    end
    return res;
  endfunction

  // Request / memory read / response sequencing with registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_misalign <= 1'b0;
      lg_q         <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      cross_q      <= 1'b0;
      w0_q         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lg_q      <= req_lg;
            uns_q     <= req_uns;
            off_q     <= req_off;
            req_ready <= 1'b0;
`ifdef LOAD_MISALIGN_SPLIT_EN
            cross_q   <= req_cross;
            state     <= RD0;
            mem_req   <= 1'b1;
            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`else
            if (req_cross) begin
              // Unsupported word-crossing access: fault without touching memory
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_misalign <= 1'b1;
              rsp_data     <= '0;
            end else begin
              state    <= RD0;
              mem_req  <= 1'b1;
              mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            end
`endif
          end
        end
        RD0: begin
          if (mem_rvalid) begin
            if (rd0_last) begin
              mem_req      <= 1'b0;
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_misalign <= 1'b0;
              rsp_data     <= merge('0, mem_rdata, off_q, lg_q, uns_q);
            end
`ifdef LOAD_MISALIGN_SPLIT_EN
            else begin
              w0_q     <= mem_rdata;
              mem_addr <= mem_addr + WORD_STEP;
              state    <= RD1;
            end
`endif
          end
        end
`ifdef LOAD_MISALIGN_SPLIT_EN
        RD1: begin
          if (mem_rvalid) begin
            mem_req      <= 1'b0;
            state        <= RESP;
            rsp_valid    <= 1'b1;
            rsp_misalign <= 1'b0;
            rsp_data     <= merge(mem_rdata, w0_q, off_q, lg_q, uns_q);
          end
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            rsp_misalign <= 1'b0;
            req_ready    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - scoreboard bench for load_align_unit (32-bit and 64-bit instances)
`timescale 1ns/1ps
module tb_load_align_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;

  logic        req_valid, req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_misalign;

  logic        r64_valid, r64_ready;
  logic [2:0]  r64_funct3;
  logic [31:0] r64_addr;
  logic        m64_req;
  logic [31:0] m64_addr;
  logic        m64_rvalid;
  logic [63:0] m64_rdata;
  logic        s64_valid, s64_ready;
  logic [63:0] s64_data;
  logic        s64_misalign;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3), .req_addr(req_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_misalign(rsp_misalign)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clock(clock), .reset(reset),
    .req_valid(r64_valid), .req_ready(r64_ready), .req_funct3(r64_funct3), .req_addr(r64_addr),
    .mem_req(m64_req), .mem_addr(m64_addr), .mem_rvalid(m64_rvalid), .mem_rdata(m64_rdata),
    .rsp_valid(s64_valid), .rsp_ready(s64_ready), .rsp_data(s64_data), .rsp_misalign(s64_misalign)
  );

  typedef struct {
    string       name;
    logic [63:0] data;
    logic        mis;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        sb64[$];
  logic [31:0] maddr_q[$];
  logic [31:0] mem32 [int unsigned];
  logic [63:0] mem64_word;
  int          rd_delay;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model for the 32-bit instance: programmable wait states, spurious rvalid when idle
  initial begin
    int          cnt;
    logic        was_req;
    logic [31:0] held;
    cnt = 0; was_req = 1'b0; held = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        cnt = 0; was_req = 1'b0; mem_rvalid = 1'b0;
      end else if (mem_req) begin
        if (was_req) check("mem_addr_stable", mem_addr, held);
        if (cnt >= rd_delay) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem32.exists(mem_addr) ? mem32[mem_addr] : 32'hDEAD_BEEF;
          if (maddr_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL mem_unexpected_read: got addr %h expected no read", mem_addr);
          end else begin
            check("mem_addr", mem_addr, maddr_q.pop_front());
          end
          cnt = 0; was_req = 1'b0;
        end else begin
          mem_rvalid = 1'b0;
          cnt++; was_req = 1'b1; held = mem_addr;
        end
      end else begin
        if (was_req) begin
          n_vec++; n_err++;
          $display("FAIL mem_req_dropped: got 0 expected 1");
        end
        cnt = 0; was_req = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5_A5A5;
      end
    end
  end

  // Response monitor for the 32-bit instance
  initial begin
    logic        prev_v;
    logic [31:0] hold_d;
    int          rise;
    exp_t        e;
    prev_v = 1'b0; hold_d = '0; rise = 0;
    forever begin
      @(negedge clock); #2;
      if (!reset) begin
        prev_v = 1'b0;
      end else if (rsp_valid) begin
        if (!prev_v) rise = cyc + 1;
        else check("rsp_data_stable", rsp_data, hold_d);
        hold_d = rsp_data;
        check("req_ready_in_resp", req_ready, 1'b0);
        check("mem_req_in_resp", mem_req, 1'b0);
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_unexpected: got %h expected no response", rsp_data);
          end else begin
            e = sb.pop_front();
            check({e.name, "_data"}, 64'(rsp_data), e.data);
            check({e.name, "_misalign"}, rsp_misalign, e.mis);
            check({e.name, "_latency"}, 64'(rise - e.acc), 64'(e.lat));
          end
          prev_v = 1'b0;
        end else begin
          prev_v = 1'b1;
        end
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  // Zero-wait memory and response monitor for the 64-bit instance
  initial begin
    exp_t e;
    m64_rvalid = 1'b0;
    m64_rdata  = '0;
    forever begin
      @(negedge clock);
      m64_rvalid = reset && m64_req;
      m64_rdata  = mem64_word;
      if (reset && m64_req) check("m64_addr", 64'(m64_addr), 64'h1000);
      #2;
      if (reset && s64_valid && s64_ready) begin
        if (sb64.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp64_unexpected: got %h expected no response", s64_data);
        end else begin
          e = sb64.pop_front();
          check({e.name, "_data"}, s64_data, e.data);
          check({e.name, "_misalign"}, s64_misalign, e.mis);
        end
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] ed, input logic em, input int lat);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clock);
    req_valid = 1'b1; req_funct3 = f3; req_addr = a;
    while (!req_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL %s_accept: got req_ready 0 expected 1", nm);
      req_valid = 1'b0;
      return;
    end
    e.name = nm; e.data = ed; e.mis = em; e.lat = lat; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic issue64(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [63:0] ed);
    int   g;
    exp_t e;
    g = 0;
    @(negedge clock);
    r64_valid = 1'b1; r64_funct3 = f3; r64_addr = a;
    while (!r64_ready && g < 200) begin
      @(negedge clock);
      g++;
    end
    if (!r64_ready) begin
      n_vec++; n_err++;
      $display("FAIL %s_accept: got req_ready 0 expected 1", nm);
      r64_valid = 1'b0;
      return;
    end
    e.name = nm; e.data = ed; e.mis = 1'b0; e.lat = 0; e.acc = 0;
    sb64.push_back(e);
    @(negedge clock);
    r64_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || sb64.size() != 0 || !req_ready || !r64_ready) && g < 300) begin
      @(negedge clock);
      g++;
    end
    check("drain_scoreboard_empty", 64'(sb.size() + sb64.size()), 64'd0);
    check("drain_mem_reads_done", 64'(maddr_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b0; rd_delay = 0; mem64_word = '0;
    req_valid = 1'b0; req_funct3 = '0; req_addr = '0; rsp_ready = 1'b1;
    r64_valid = 1'b0; r64_funct3 = '0; r64_addr = '0; s64_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_misalign", rsp_misalign, 1'b0);
    check("rst64_req_ready", r64_ready, 1'b1);
    @(negedge clock);
    reset = 1'b1;

    // 64-bit datapath
    mem64_word = 64'h8000_0000_0000_0000;
    issue64("d64_lwu_1004", 3'b110, 32'h1004, 64'h0000_0000_8000_0000);
    issue64("d64_lw_1004",  3'b010, 32'h1004, 64'hFFFF_FFFF_8000_0000);
    issue64("d64_ld_1000",  3'b011, 32'h1000, 64'h8000_0000_0000_0000);
    issue64("d64_lb_1007",  3'b000, 32'h1007, 64'hFFFF_FFFF_FFFF_FF80);
    issue64("d64_lbu_1007", 3'b100, 32'h1007, 64'h0000_0000_0000_0080);
    drain();

    // Aligned / non-crossing 32-bit loads
    mem32[32'h100] = 32'h8011_2233;
    maddr_q.push_back(32'h100); issue("lb_103",  3'b000, 32'h103, 64'hFFFF_FF80, 1'b0, 2);
    maddr_q.push_back(32'h100); issue("lbu_101", 3'b100, 32'h101, 64'h0000_0022, 1'b0, 2);
    maddr_q.push_back(32'h100); issue("lb_100",  3'b000, 32'h100, 64'h0000_0033, 1'b0, 2);
    maddr_q.push_back(32'h100); issue("lh_100",  3'b001, 32'h100, 64'h0000_2233, 1'b0, 2);
    drain();
    mem32[32'h100] = 32'hBEEF_1234;
    mem32[32'h104] = 32'h8877_6655;
    maddr_q.push_back(32'h100); issue("lhu_102", 3'b101, 32'h102, 64'h0000_BEEF, 1'b0, 2);
    maddr_q.push_back(32'h100); issue("lh_102",  3'b001, 32'h102, 64'hFFFF_BEEF, 1'b0, 2);
    maddr_q.push_back(32'h104); issue("lwu_104", 3'b110, 32'h104, 64'h8877_6655, 1'b0, 2);
    maddr_q.push_back(32'h104); issue("ld_104",  3'b011, 32'h104, 64'h8877_6655, 1'b0, 2);
    drain();

    // Word-crossing loads
    mem32[32'h100] = 32'h4433_2211;
`ifdef LOAD_MISALIGN_SPLIT_EN
    maddr_q.push_back(32'h100); maddr_q.push_back(32'h104);
    issue("lw_101_cross", 3'b010, 32'h101, 64'h5544_3322, 1'b0, 3);
    maddr_q.push_back(32'h100); maddr_q.push_back(32'h104);
    issue("lh_103_cross", 3'b001, 32'h103, 64'h0000_5544, 1'b0, 3);
    maddr_q.push_back(32'h100); maddr_q.push_back(32'h104);
    issue("lw_103_cross", 3'b010, 32'h103, 64'h7766_5544, 1'b0, 3);
`else
    issue("lw_101_cross", 3'b010, 32'h101, 64'h0, 1'b1, 1);
    issue("lh_103_cross", 3'b001, 32'h103, 64'h0, 1'b1, 1);
    issue("lw_103_cross", 3'b010, 32'h103, 64'h0, 1'b1, 1);
`endif
    maddr_q.push_back(32'h100); issue("lb_103_nocross", 3'b000, 32'h103, 64'h0000_0044, 1'b0, 2);
    drain();

    // Memory wait states
    mem32[32'h200] = 32'hCAFE_F00D;
    mem32[32'h204] = 32'h1357_9BDF;
    rd_delay = 3;
    maddr_q.push_back(32'h200); issue("lw_200_wait3", 3'b010, 32'h200, 64'hCAFE_F00D, 1'b0, 5);
    drain();
    rd_delay = 1;
`ifdef LOAD_MISALIGN_SPLIT_EN
    maddr_q.push_back(32'h200); maddr_q.push_back(32'h204);
    issue("lw_202_cross_wait1", 3'b010, 32'h202, 64'h9BDF_CAFE, 1'b0, 5);
`else
    issue("lw_202_cross_wait1", 3'b010, 32'h202, 64'h0, 1'b1, 1);
`endif
    drain();
    rd_delay = 0;

    // Response back-pressure with a second request waiting
    mem32[32'h300] = 32'h1234_5678;
    rsp_ready = 1'b0;
    maddr_q.push_back(32'h300);
    issue("lw_300_stall", 3'b010, 32'h300, 64'h1234_5678, 1'b0, 2);
    fork
      begin
        int g;
        g = 0;
        while (!rsp_valid && g < 50) begin
          @(negedge clock);
          g++;
        end
        repeat (3) @(negedge clock);
        rsp_ready = 1'b1;
      end
      begin
        maddr_q.push_back(32'h300);
        issue("lbu_301_after_stall", 3'b100, 32'h301, 64'h0000_0056, 1'b0, 2);
      end
    join
    drain();

    // Reset in the middle of a transaction
    rd_delay = 6;
    mem32[32'h104] = 32'h8877_6655;
    begin
      int g;
      g = 0;
`ifdef LOAD_MISALIGN_SPLIT_EN
      maddr_q.push_back(32'h104);
      issue("lw_105_aborted", 3'b010, 32'h105, 64'h0, 1'b0, 0);
      while (!(mem_req && mem_addr == 32'h108) && g < 60) begin
        @(negedge clock);
        g++;
      end
      check("reached_rd1", mem_req && mem_addr == 32'h108, 1'b1);
`else
      issue("lw_104_aborted", 3'b010, 32'h104, 64'h0, 1'b0, 0);
      while (!mem_req && g < 60) begin
        @(negedge clock);
        g++;
      end
      check("reached_rd0", mem_req, 1'b1);
      @(negedge clock);
`endif
    end
    reset = 1'b0;
    #1;
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rsp_data", 64'(rsp_data), 64'd0);
    check("abort_rsp_misalign", rsp_misalign, 1'b0);
    sb.delete();
    maddr_q.delete();
    rd_delay = 0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("no_rsp_after_abort", rsp_valid, 1'b0);

    // Recovery after abort
    mem32[32'h100] = 32'h8011_2233;
    maddr_q.push_back(32'h100); issue("lh_102_recover", 3'b001, 32'h102, 64'hFFFF_8011, 1'b0, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
